// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming datapath: FSM encoding, stride
// encoding and the window element offset helper.
package cnn_pkg;

    localparam int K_MIN = 2;
    localparam int K_MAX = 7;

    localparam logic STRIDE_1 = 1'b0;
    localparam logic STRIDE_2 = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cws_state_e;

    // Bit offset of window element (r, c, ch); r = 0 is the oldest row, c = 0 the leftmost column.
    function automatic int elem_off(input int r, input int c, input int ch,
                                    input int k, input int chn, input int dw);
        return ((r * k + c) * chn + ch) * dw;
    endfunction

endpackage

// File: rtl/conv_line_store.sv
// One image line of pixels: single write port, asynchronous read-first access
// at the same address so the old contents can be forwarded to the next line.
module conv_line_store #(
    parameter int DEPTH = 1024,
    parameter int PW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [PW-1:0] wdata,
    output logic [PW-1:0] rdata
);

    logic [PW-1:0] mem_r [DEPTH];

    // Line storage write; contents deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/conv_window_stream.sv
// Streaming K x K x CH sliding-window generator: raster pixels in, valid-only
// (unpadded) convolution windows out under valid/ready flow control.
module conv_window_stream
    import cnn_pkg::*;
#(
    parameter int K     = 3,
    parameter int DW    = 8,
    parameter int CH    = 1,
    parameter int MAX_W = 1024,
    parameter int MAX_H = 1024,
    parameter int WB    = $clog2(MAX_W + 1),
    parameter int HB    = $clog2(MAX_H + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WB-1:0]          cfg_width,
    input  logic [HB-1:0]          cfg_height,
    input  logic                   cfg_stride2,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH*DW-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [K*K*CH*DW-1:0]   out_window,
    output logic                   out_last,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   cfg_err
);

    localparam int PW = CH * DW;
    localparam int CW = K * PW;
    localparam int AW = $clog2(MAX_W);

    localparam logic [WB-1:0] K_W     = WB'(K);
    localparam logic [HB-1:0] K_H     = HB'(K);
    localparam logic [WB-1:0] K_W1    = WB'(K - 1);
    localparam logic [HB-1:0] K_H1    = HB'(K - 1);
    localparam logic [WB-1:0] MAX_W_C = WB'(MAX_W);
    localparam logic [HB-1:0] MAX_H_C = HB'(MAX_H);
    localparam logic          KM1_LSB = 1'((K - 1) % 2);

    cws_state_e     state_r;
    cws_state_e     state_nxt_s;
    logic [WB-1:0]  width_r;
    logic [HB-1:0]  height_r;
    logic           stride2_r;
    logic [WB-1:0]  col_r;
    logic [HB-1:0]  row_r;
    logic           cfg_err_r;
    logic           out_valid_r;
    logic           out_last_r;
    logic           frame_done_r;
    logic [CW-1:0]  win_r [K];
    logic [CW-1:0]  new_col_s;
    logic [PW-1:0]  rd_s [K-1];
    logic           cfg_legal_s;
    logic           accept_s;
    logic           col_last_s;
    logic           row_last_s;
    logic           pix_last_s;
    logic           emit_s;

    assign cfg_legal_s = (cfg_width >= K_W) && (cfg_width <= MAX_W_C) &&
                         (cfg_height >= K_H) && (cfg_height <= MAX_H_C);
    // start wins over a same-cycle handshake; that pixel is dropped
    assign accept_s   = in_valid && in_ready && !start;
    assign col_last_s = (col_r == (width_r - WB'(1)));
    assign row_last_s = (row_r == (height_r - HB'(1)));
    assign pix_last_s = col_last_s && row_last_s;
    // Row/column gating also hides the previous row's columns and stale lines of an older frame
    assign emit_s     = (col_r >= K_W1) && (row_r >= K_H1) &&
                        ((stride2_r != STRIDE_2) || ((col_r[0] == KM1_LSB) && (row_r[0] == KM1_LSB)));

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && cfg_legal_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start) begin
                    state_nxt_s = cfg_legal_s ? ST_RUN : ST_IDLE;
                end else if (accept_s && pix_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode; only one window may be outstanding.
    always_comb begin
        busy     = 1'b0;
        in_ready = 1'b0;
        case (state_r)
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = !out_valid_r || out_ready;
            end
            default: begin
                busy     = 1'b0;
                in_ready = 1'b0;
            end
        endcase
    end

    // Frame configuration and raster position counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            width_r   <= '0;
            height_r  <= '0;
            stride2_r <= 1'b0;
            col_r     <= '0;
            row_r     <= '0;
            cfg_err_r <= 1'b0;
        end else if (start) begin
            width_r   <= cfg_width;
            height_r  <= cfg_height;
            stride2_r <= cfg_stride2;
            col_r     <= '0;
            row_r     <= '0;
            cfg_err_r <= !cfg_legal_s;
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= '0;
                row_r <= row_r + HB'(1);
            end else begin
                col_r <= col_r + WB'(1);
            end
        end
    end

    // Window handshake, last-window flag and end-of-frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= accept_s && pix_last_s;
            if (start) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else if (accept_s) begin
                out_valid_r <= emit_s;
                out_last_r  <= emit_s && pix_last_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
        end
    end

    genvar li;
    for (li = 0; li < K - 1; li++) begin : g_line
        logic [PW-1:0] wdata_s;
        if (li == 0) begin : g_first
            assign wdata_s = in_data;
        end else begin : g_chain
            assign wdata_s = rd_s[li-1];
        end
        conv_line_store #(
            .DEPTH (MAX_W),
            .PW    (PW),
            .AW    (AW)
        ) u_line (
            .clk   (clk),
            .we    (accept_s),
            .addr  (col_r[AW-1:0]),
            .wdata (wdata_s),
            .rdata (rd_s[li])
        );
    end

    // New rightmost column: oldest stored line at row 0, incoming pixel at row K-1.
    always_comb begin
        new_col_s = '0;
        for (int r = 0; r < K - 1; r++) begin
            new_col_s[r*PW +: PW] = rd_s[K-2-r];
        end
        new_col_s[(K-1)*PW +: PW] = in_data;
    end

    // Window column registers; frozen while a window is stalled because nothing is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < K; c++) begin
                win_r[c] <= '0;
            end
        end else if (accept_s) begin
            for (int c = 0; c < K - 1; c++) begin
                win_r[c] <= win_r[c+1];
            end
            win_r[K-1] <= new_col_s;
        end
    end

    genvar gr, gc, gch;
    for (gr = 0; gr < K; gr++) begin : g_row
        for (gc = 0; gc < K; gc++) begin : g_col
            for (gch = 0; gch < CH; gch++) begin : g_ch
                assign out_window[elem_off(gr, gc, gch, K, CH, DW) +: DW] =
                    win_r[gc][(gr*CH+gch)*DW +: DW];
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign frame_done = frame_done_r;
    assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_conv_window_stream.sv
// Directed bench for conv_window_stream: a frame-level window model feeds a
// scoreboard checked every cycle, backed by hand-computed window literals.
module tb_conv_window_stream;

    localparam int K     = 3;
    localparam int DW    = 8;
    localparam int CH    = 1;
    localparam int MAX_W = 1024;
    localparam int MAX_H = 1024;
    localparam int WB    = $clog2(MAX_W + 1);
    localparam int HB    = $clog2(MAX_H + 1);
    localparam int WIN_W = K * K * CH * DW;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [WB-1:0]     cfg_width;
    logic [HB-1:0]     cfg_height;
    logic              cfg_stride2;
    logic              in_valid;
    logic              in_ready;
    logic [CH*DW-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIN_W-1:0]  out_window;
    logic              out_last;
    logic              frame_done;
    logic              busy;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;

    logic [WIN_W-1:0] exp_win_q [$];
    logic             exp_last_q [$];
    int               obs_cnt = 0;
    int               fd_cnt  = 0;
    logic [WIN_W-1:0] first_obs = '0;
    logic [WIN_W-1:0] last_obs  = '0;
    logic             last_obs_flag = 1'b0;
    logic             held_v = 1'b0;
    logic [WIN_W-1:0] held_win = '0;
    logic             held_last = 1'b0;
    logic             tog_mode = 1'b0;
    logic [7:0]       rdy_pat = 8'b1001_0110;
    logic [2:0]       pat_idx = 3'd0;

    conv_window_stream #(
        .K (K), .DW (DW), .CH (CH), .MAX_W (MAX_W), .MAX_H (MAX_H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_stride2 (cfg_stride2),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_window  (out_window),
        .out_last    (out_last),
        .frame_done  (frame_done),
        .busy        (busy),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
        return base + 8'(r * 16 + c);
    endfunction

    // Every window whose top-left corner lies on the stride grid and fits in the image.
    task automatic build_frame(input int w, input int h, input int s, input logic [7:0] base);
        logic [WIN_W-1:0] wv;
        exp_win_q.delete();
        exp_last_q.delete();
        for (int tr = 0; tr + K <= h; tr += s) begin
            for (int tc = 0; tc + K <= w; tc += s) begin
                wv = '0;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        wv[(r*K+c)*DW +: DW] = pix(base, tr + r, tc + c);
                    end
                end
                exp_win_q.push_back(wv);
                exp_last_q.push_back((tr + K == h) && (tc + K == w));
            end
        end
        obs_cnt = 0;
        fd_cnt  = 0;
    endtask

    task automatic upd_ready();
        if (tog_mode) begin
            out_ready = rdy_pat[pat_idx];
            pat_idx   = pat_idx + 3'd1;
        end
    endtask

    task automatic do_start(input int w, input int h, input logic s2, input logic v);
        in_valid    = v;
        in_data     = 8'hEE;
        start       = 1'b1;
        cfg_width   = WB'(w);
        cfg_height  = HB'(h);
        cfg_stride2 = s2;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            upd_ready();
            n++;
        end
        in_valid = 1'b0;
        chk("pixel accepted", 128'(acc), 128'(1'b1));
    endtask

    task automatic run_frame(input int w, input logic [7:0] base, input int npix);
        for (int i = 0; i < npix; i++) begin
            send(pix(base, i / w, i % w));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_win_q.size() > 0 && n < 500) begin
            @(posedge clk); #1;
            upd_ready();
            n++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("all windows seen", 128'(exp_win_q.size()), 128'(0));
    endtask

    // Scoreboard: checks flow control, stall stability and each consumed window.
    always begin
        @(negedge clk);
        chk("in_ready rule", 128'(in_ready), 128'(busy && (!out_valid || out_ready)));
        if (held_v && !reset) begin
            chk("stall valid held", 128'(out_valid), 128'(1'b1));
            chk("stall window held", 128'(out_window), 128'(held_win));
            chk("stall last held", 128'(out_last), 128'(held_last));
        end
        if (out_valid && out_ready) begin
            if (exp_win_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected window: got %h, none expected", out_window);
            end else begin
                chk("window", 128'(out_window), 128'(exp_win_q.pop_front()));
                chk("window last", 128'(out_last), 128'(exp_last_q.pop_front()));
            end
            if (obs_cnt == 0) begin
                first_obs = out_window;
            end
            last_obs      = out_window;
            last_obs_flag = out_last;
            obs_cnt++;
        end
        if (frame_done) begin
            fd_cnt++;
        end
        held_v    = out_valid && !out_ready;
        held_win  = out_window;
        held_last = out_last;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0; cfg_stride2 = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset out_window", 128'(out_window), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset in_ready", 128'(in_ready), 128'(0));
        chk("reset cfg_err", 128'(cfg_err), 128'(0));
        chk("reset frame_done", 128'(frame_done), 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // 5x4 stride 1
        build_frame(5, 4, 1, 8'h00);
        do_start(5, 4, 1'b0, 1'b0);
        chk("t1 busy", 128'(busy), 128'(1));
        chk("t1 cfg_err", 128'(cfg_err), 128'(0));
        run_frame(5, 8'h00, 20);
        chk("t1 frame_done", 128'(frame_done), 128'(1));
        chk("t1 busy end", 128'(busy), 128'(0));
        drain();
        chk("t1 count", 128'(obs_cnt), 128'(6));
        chk("t1 first", 128'(first_obs), 128'(72'h222120_121110_020100));
        chk("t1 last window", 128'(last_obs), 128'(72'h343332_242322_141312));
        chk("t1 last flag", 128'(last_obs_flag), 128'(1));
        chk("t1 frame_done count", 128'(fd_cnt), 128'(1));

        // 7x7 stride 2
        build_frame(7, 7, 2, 8'h00);
        do_start(7, 7, 1'b1, 1'b0);
        run_frame(7, 8'h00, 49);
        drain();
        chk("t2 count", 128'(obs_cnt), 128'(9));
        chk("t2 first", 128'(first_obs), 128'(72'h222120_121110_020100));
        chk("t2 last window", 128'(last_obs), 128'(72'h666564_565554_464544));
        chk("t2 last flag", 128'(last_obs_flag), 128'(1));

        // 5x4 with downstream back-pressure
        tog_mode = 1'b1;
        build_frame(5, 4, 1, 8'h00);
        do_start(5, 4, 1'b0, 1'b0);
        run_frame(5, 8'h00, 20);
        drain();
        tog_mode = 1'b0;
        out_ready = 1'b1;
        chk("t3 count", 128'(obs_cnt), 128'(6));
        chk("t3 last window", 128'(last_obs), 128'(72'h343332_242322_141312));

        // illegal width, then a legal frame
        do_start(2, 4, 1'b0, 1'b0);
        chk("t4 cfg_err", 128'(cfg_err), 128'(1));
        chk("t4 busy", 128'(busy), 128'(0));
        chk("t4 in_ready", 128'(in_ready), 128'(0));
        build_frame(5, 4, 1, 8'h00);
        do_start(5, 4, 1'b0, 1'b0);
        chk("t4 cfg_err cleared", 128'(cfg_err), 128'(0));
        run_frame(5, 8'h00, 20);
        drain();
        chk("t4 count", 128'(obs_cnt), 128'(6));
        chk("t4 frame_done count", 128'(fd_cnt), 128'(1));

        // abort after 8 pixels; the pixel offered with start is dropped
        build_frame(5, 4, 1, 8'h00);
        do_start(5, 4, 1'b0, 1'b0);
        run_frame(5, 8'h00, 8);
        build_frame(4, 3, 1, 8'h80);
        do_start(4, 3, 1'b0, 1'b1);
        chk("t5 busy", 128'(busy), 128'(1));
        run_frame(4, 8'h80, 12);
        drain();
        chk("t5 count", 128'(obs_cnt), 128'(2));
        chk("t5 first", 128'(first_obs), 128'(72'hA2A1A0_929190_828180));
        chk("t5 last window", 128'(last_obs), 128'(72'hA3A2A1_939291_838281));
        chk("t5 last flag", 128'(last_obs_flag), 128'(1));
        chk("t5 frame_done count", 128'(fd_cnt), 128'(1));

        // async reset while a window is pending
        build_frame(5, 4, 1, 8'h00);
        do_start(5, 4, 1'b0, 1'b0);
        out_ready = 1'b0;
        run_frame(5, 8'h00, 13);
        chk("t6 pending window", 128'(out_valid), 128'(1));
        #1;
        reset = 1'b1;
        #1;
        chk("t6 out_valid", 128'(out_valid), 128'(0));
        chk("t6 out_window", 128'(out_window), 128'(0));
        chk("t6 busy", 128'(busy), 128'(0));
        chk("t6 in_ready", 128'(in_ready), 128'(0));
        chk("t6 out_last", 128'(out_last), 128'(0));
        exp_win_q.delete();
        exp_last_q.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        build_frame(5, 4, 1, 8'h00);
        do_start(5, 4, 1'b0, 1'b0);
        run_frame(5, 8'h00, 20);
        drain();
        chk("t6 count", 128'(obs_cnt), 128'(6));
        chk("t6 first", 128'(first_obs), 128'(72'h222120_121110_020100));
        chk("t6 frame_done count", 128'(fd_cnt), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_stream.md
Name: conv_window_stream

Overview:
Streaming K x K sliding-window generator for the CNN convolution datapath. Accepts one multi-channel pixel per handshake in raster order, keeps K-1 previous image lines in on-chip line stores, and emits a full K x K x CH window each time the window lies completely inside the image ("valid" convolution, no padding). Frame size and stride are set at run time. Output feeds the multiply-accumulate filter array under valid/ready flow control.

Parameters:
K, 3, window size (rows = columns), legal 2..7
DW, 8, bits per channel sample
CH, 1, channels per pixel
MAX_W, 1024, maximum image width (line store depth)
MAX_H, 1024, maximum image height
WB, clog2(MAX_W+1), width/column counter bits
HB, clog2(MAX_H+1), height/row counter bits

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: latch config, begin new frame (aborts any frame in progress)
cfg_width  in  WB  image width in pixels
cfg_height  in  HB  image height in pixels
cfg_stride2  in  1  0 = stride 1, 1 = stride 2
in_valid  in  1  input pixel valid
in_ready  out  1  input pixel accepted when in_valid && in_ready
in_data  in  CH*DW  pixel, channel c at [c*DW +: DW]
out_valid  out  1  window valid
out_ready  in  1  downstream accepts window
out_window  out  K*K*CH*DW  window; element (r,c,ch) at [((r*K+c)*CH+ch)*DW +: DW], r=0 oldest row, c=0 leftmost column
out_last  out  1  qualifies last window of the frame
frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted
busy  out  1  frame in progress
cfg_err  out  1  last start carried an illegal config

Behaviour:
- Reset: out_valid, out_last, frame_done, busy, cfg_err = 0; out_window = 0; in_ready = 0; counters = 0. Line store contents are not reset.
- start: sample cfg_*. Legal iff K <= cfg_width <= MAX_W and K <= cfg_height <= MAX_H. If legal: busy=1, cfg_err=0, col=row=0, out_valid cleared. If illegal: cfg_err=1, busy=0, block stays idle. start takes priority over a same-cycle input handshake; that pixel is dropped.
- States: IDLE (in_ready=0), RUN. RUN -> IDLE on acceptance of pixel (cfg_height-1, cfg_width-1); frame_done pulses the following cycle.
- in_ready = busy && (!out_valid || out_ready). Only one window is outstanding; no skid buffer.
- On acceptance at (row,col): column col of each line store shifts down one line (read-first: old contents move to the next older line); new pixel written to line 0. The K window column registers shift left, and the new rightmost column = {K-1 stored lines at col, in_data}.
- Window emission: out_valid is set the cycle after acceptance (latency 1) iff row >= K-1, col >= K-1, and for stride 2, (row-(K-1)) and (col-(K-1)) are both even. out_last is set with the window at (cfg_height-1, cfg_width-1) when that window is emitted. out_window is held stable while out_valid && !out_ready.
- At col = cfg_width-1: col wraps to 0, row++. Window columns from the previous row never qualify, because col >= K-1 gating covers row wrap.
- Counters are compared at WB/HB width; no arithmetic overflow is possible for legal configs.
- Stale line-store data from a previous frame is never emitted, because row >= K-1 gating covers it.
- Windows per frame: ((H-K)/S+1)*((W-K)/S+1), using integer division.
- Async reset mid-frame: return to reset state immediately; a pending window is discarded.

Decomposition:
- Package cnn_pkg: window/sample element helpers (element index function r,c,ch -> bit offset), stride encoding constants, max legal K.
- Sub-module conv_line_store: one line of MAX_W x CH*DW, one write port, asynchronous read at the same address, read-first. Instantiate K-1 copies chained in the top level.

Test Plan:
- K=3, W=5, H=4, stride 1, pixel = row*16+col, out_ready=1 -> 6 windows. First window rows {00,01,02},{10,11,12},{20,21,22}. Last is centred on 0x23 with out_last=1. frame_done pulses once.
- K=3, W=7, H=7, stride 2 -> 9 windows with top-left corners at rows/cols {0,2,4}. No window at odd offsets.
- Same as the first case, with out_ready toggled 1-0-0-1 randomly -> in_ready low whenever out_valid && !out_ready. Window sequence identical to the first case; out_window is stable during stalls.
- start with cfg_width=2 (K=3) -> cfg_err=1, busy=0, in_ready=0. A following legal start clears cfg_err and the frame completes normally.
- start reissued mid-frame after 8 pixels with new W=4, H=3 -> old frame aborted, no old windows emitted. New frame gives 2 windows from the new data only.
- reset asserted mid-frame while out_valid=1 -> all outputs 0 the same cycle. After release plus a start, a full frame runs correctly.
